// File: rtl/led_pattern_engine.sv
// LED pattern engine: shadowed config from the AXI-Lite register file drives static/blink/rotate/bounce patterns with PWM.
// Optional build macro LED_BREATHE_EN adds a ctrl[3] breathing duty ramp.
module led_pattern_engine #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_W    = 8,
  parameter int STEP_W   = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [31:0]         cfg_ctrl,
  input  logic [31:0]         cfg_pattern,
  input  logic [31:0]         cfg_period,
  input  logic [31:0]         cfg_duty,
  input  logic [3:0]          cfg_wr_strb,
  output logic [NUM_LEDS-1:0] led,
  output logic [STEP_W-1:0]   step_count,
  output logic                busy
);

  typedef enum logic [2:0] {
    OFF,
    RUN_STATIC,
    RUN_BLINK,
    RUN_ROTATE,
    RUN_BOUNCE
  } state_t;

  state_t              state;
  logic                pending;
  logic                dir_right;
  logic                phase;
  logic [NUM_LEDS-1:0] pattern_cur;
  logic [31:0]         shadow_period;
  logic [31:0]         presc;
  logic [PWM_W-1:0]    shadow_duty;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [PWM_W-1:0]    eff_duty;

  logic                animated;
  logic                prd_hit;
  logic                tick;
  logic                apply;
  logic [31:0]         per_m1;
  logic                pwm_on_p0;
  logic [NUM_LEDS-1:0] disp_p0;
  logic [NUM_LEDS:0]   bounce_nxt;
  logic                unused_cfg;

  function automatic state_t pick_state(input logic [2:0] c);
    if (!c[0]) return OFF;
    case (c[2:1])
      2'b00:   return RUN_STATIC;
      2'b01:   return RUN_BLINK;
      2'b10:   return RUN_ROTATE;
      default: return RUN_BOUNCE;
    endcase
  endfunction

  function automatic logic [NUM_LEDS-1:0] rotate_left(input logic [NUM_LEDS-1:0] p);
    return {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
  endfunction

  // Returns {direction_right, next_pattern}; a set edge bit reverses before shifting.
  function automatic logic [NUM_LEDS:0] bounce_step(input logic [NUM_LEDS-1:0] p,
                                                     input logic right);
    logic r;
    r = right;
    if (p == '0 || p == '1) return {right, p};
    if (!r && p[NUM_LEDS-1]) r = 1'b1;
    else if (r && p[0])      r = 1'b0;
    return {r, (r ? (p >> 1) : (p << 1))};
  endfunction

  assign unused_cfg = ^{cfg_ctrl, cfg_pattern, cfg_duty};

  assign animated   = (state == RUN_BLINK) || (state == RUN_ROTATE) || (state == RUN_BOUNCE);
  assign per_m1     = (shadow_period == 32'd0) ? 32'd0 : shadow_period - 32'd1;
  assign prd_hit    = (state != OFF) && (presc == per_m1);
  assign tick       = prd_hit && animated;
  assign apply      = pending && (tick || state == OFF || state == RUN_STATIC);
  assign bounce_nxt = bounce_step(pattern_cur, dir_right);

  // Stage p0: display pattern and PWM gate from current state, registered onto led
  assign disp_p0   = (state == RUN_BLINK && !phase) ? '0 : pattern_cur;
  assign pwm_on_p0 = (pwm_cnt < eff_duty) || (&eff_duty);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= OFF;
      pending       <= 1'b0;
      dir_right     <= 1'b0;
      phase         <= 1'b0;
      pattern_cur   <= '0;
      shadow_period <= '0;
      shadow_duty   <= '0;
      presc         <= '0;
      pwm_cnt       <= '0;
      step_count    <= '0;
      led           <= '0;
      busy          <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led     <= (state == OFF) ? '0 : (disp_p0 & {NUM_LEDS{pwm_on_p0}});
      busy    <= animated;
      if (apply) begin
        state         <= pick_state(cfg_ctrl[2:0]);
        pending       <= |cfg_wr_strb;
        shadow_period <= cfg_period;
        shadow_duty   <= cfg_duty[PWM_W-1:0];
        pattern_cur   <= cfg_pattern[NUM_LEDS-1:0];
        step_count    <= '0;
        presc         <= '0;
        dir_right     <= 1'b0;
        phase         <= 1'b1;
      end else begin
        pending <= pending | (|cfg_wr_strb);
        if (state != OFF) presc <= prd_hit ? 32'd0 : presc + 32'd1;
        if (tick) begin
          step_count <= step_count + STEP_W'(1);
          case (state)
            RUN_BLINK:  phase       <= ~phase;
            RUN_ROTATE: pattern_cur <= rotate_left(pattern_cur);
            RUN_BOUNCE: begin
              dir_right   <= bounce_nxt[NUM_LEDS];
              pattern_cur <= bounce_nxt[NUM_LEDS-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LED_BREATHE_EN
  logic             breathe;
  logic             ramp_down;
  logic [PWM_W-1:0] ramp;

  assign eff_duty = breathe ? ramp : shadow_duty;

  // Triangle ramp 0 -> shadow duty -> 0, advanced on every period boundary in any run state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      breathe   <= 1'b0;
      ramp_down <= 1'b0;
      ramp      <= '0;
    end else if (apply) begin
      breathe   <= cfg_ctrl[3];
      ramp_down <= 1'b0;
      ramp      <= '0;
    end else if (prd_hit && breathe) begin
      if (!ramp_down) begin
        if (ramp >= shadow_duty) begin
          ramp_down <= 1'b1;
          ramp      <= (ramp == '0) ? '0 : ramp - PWM_W'(1);
        end else begin
          ramp <= ramp + PWM_W'(1);
        end
      end else if (ramp == '0) begin
        ramp_down <= 1'b0;
        ramp      <= (shadow_duty == '0) ? '0 : PWM_W'(1);
      end else begin
        ramp <= ramp - PWM_W'(1);
      end
    end
  end
`else
  assign eff_duty = shadow_duty;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: stimulus queues cycle-tagged expectations, a negedge monitor pops and compares.
module tb_led_pattern_engine;

  logic        ACLK        = 1'b0;
  logic        ARESETN     = 1'b0;
  logic [31:0] cfg_ctrl    = 32'd0;
  logic [31:0] cfg_pattern = 32'd0;
  logic [31:0] cfg_period  = 32'd0;
  logic [31:0] cfg_duty    = 32'd0;
  logic [3:0]  cfg_wr_strb = 4'd0;
  logic [3:0]  led;
  logic [15:0] step_count;
  logic        busy;

  led_pattern_engine #(.NUM_LEDS(4), .PWM_W(8), .STEP_W(16)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_ctrl    (cfg_ctrl),
    .cfg_pattern (cfg_pattern),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_wr_strb (cfg_wr_strb),
    .led         (led),
    .step_count  (step_count),
    .busy        (busy)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        chk_led;
    logic [3:0]  led;
    logic        chk_step;
    logic [15:0] step;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] rot_seq [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] bnc_seq [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

  task automatic push(input int c, input logic cl, input logic [3:0] l, input logic cs,
                      input logic [15:0] s, input logic b, input string n);
    exp_t e;
    e.cyc = c; e.chk_led = cl; e.led = l; e.chk_step = cs; e.step = s; e.busy = b; e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic write_cfg(input logic [31:0] c, input logic [31:0] p,
                           input logic [31:0] per, input logic [31:0] d);
    cfg_ctrl    = c;
    cfg_pattern = p;
    cfg_period  = per;
    cfg_duty    = d;
    cfg_wr_strb = 4'hF;
    tick();
    cfg_wr_strb = 4'h0;
  endtask

  // Monitor: compares every expectation due at or before the current cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || (e.chk_led && led !== e.led) ||
            (e.chk_step && step_count !== e.step) || busy !== e.busy) begin
          n_bad++;
          $display("FAIL %s cyc=%0d due=%0d: got led=%h step=%0d busy=%b, required led=%h step=%0d busy=%b",
                   e.name, cyc, e.cyc, led, step_count, busy, e.led, e.step, e.busy);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   rel;
    int   tt;
    logic ph;
    logic pw;

    tick();
    push(cyc, 1'b1, 4'h0, 1'b1, 16'd0, 1'b0, "reset_hold");
    tick();
    tick();
    ARESETN = 1'b1;
    rel = cyc;
    for (int k = 10; k <= 1000; k += 10) push(rel + k, 1'b1, 4'h0, 1'b1, 16'd0, 1'b0, "idle");
    wait_until(rel + 1000);

    write_cfg(32'h1, 32'h5, 32'd0, 32'hFF);
    base = cyc;
    push(base + 1, 1'b1, 4'h0, 1'b1, 16'd0, 1'b0, "static_latency");
    for (int k = 2; k <= 12; k += 2) push(base + k, 1'b1, 4'h5, 1'b1, 16'd0, 1'b0, "static");
    wait_until(base + 12);

    write_cfg(32'h5, 32'h1, 32'd4, 32'hFF);
    base = cyc;
    foreach (rot_seq[i]) begin
      for (int j = 0; j < 4; j++)
        push(base + 2 + 4 * i + j, 1'b1, rot_seq[i], 1'b1, 16'((4 * i + j + 1) / 4), 1'b1, "rotate");
    end
    wait_until(base + 22);

    ARESETN = 1'b0;
    push(cyc, 1'b1, 4'h0, 1'b1, 16'd0, 1'b0, "reset_async");
    tick();
    tick();
    tick();
    ARESETN = 1'b1;
    rel = cyc;
    for (int k = 2; k <= 20; k += 2) push(rel + k, 1'b1, 4'h0, 1'b1, 16'd0, 1'b0, "reset_stays_off");
    wait_until(rel + 20);

    write_cfg(32'h7, 32'h1, 32'd1, 32'hFF);
    base = cyc;
    foreach (bnc_seq[k]) push(base + 2 + k, 1'b1, bnc_seq[k], 1'b1, 16'(k + 1), 1'b1, "bounce");
    wait_until(base + 9);

    write_cfg(32'h3, 32'hF, 32'd10, 32'h40);
    base = cyc;
    for (int e = base + 2; e <= base + 261; e++) begin
      ph = (((e - base - 2) / 10) % 2) == 0;
      pw = ((e - 1 - rel) % 256) < 64;
      push(e, 1'b1, (ph && pw) ? 4'hF : 4'h0, 1'b1, 16'((e - base - 1) / 10), 1'b1, "blink");
    end
    wait_until(base + 263);

    write_cfg(32'h3, 32'hF, 32'd3, 32'hFF);
    tt = base + 271;
    for (int e = cyc; e < tt; e++) push(e, 1'b0, 4'h0, 1'b1, 16'd26, 1'b1, "blink_period_held");
    push(tt, 1'b0, 4'h0, 1'b1, 16'd0, 1'b1, "blink_reapply");
    for (int k = 1; k <= 9; k++)
      push(tt + k, 1'b1, (((k - 1) / 3) % 2 == 0) ? 4'hF : 4'h0, 1'b1, 16'(k / 3), 1'b1, "blink_new_period");
    wait_until(tt + 12);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
